// File: rtl/stopwatch_timer.sv
// stopwatch_timer: mm:ss stopwatch/countdown with prescaled 1 s tick, lap capture and expiry strobe
module stopwatch_timer #(
  parameter int CLK_DIV = 1,
  parameter int MIN_W = 8,
  parameter int MAX_MIN = 2**MIN_W-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             rst,
  input  logic             dir,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             expired
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [MIN_W-1:0] MAXM = MIN_W'(MAX_MIN);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV-1);
  typedef enum logic [1:0] {IDLE = 2'b00, PAUSED = 2'b01, RUNNING = 2'b10, EXPIRED = 2'b11} state_t;
  state_t state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d, lap_min_q, lap_min_d;
  logic [5:0] sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic mode_q, mode_d, lap_valid_q, lap_valid_d, expired_q, expired_d;
  logic run, tick, zero;
  always_comb begin
    run = state_q == RUNNING;
    tick = run && pre_q == PMAX;
    zero = min_q == '0 && sec_q == '0;
    state_d = state_q;
    min_d = min_q;
    sec_d = sec_q;
    pre_d = '0;
    mode_d = mode_q;
    expired_d = 1'b0;
    lap_valid_d = run && lap && !rst;
    lap_min_d = lap_valid_d ? min_q : lap_min_q;
    lap_sec_d = lap_valid_d ? sec_q : lap_sec_q;
    // only the highest-priority asserted command is considered, even if it is ignored
    if (rst) begin
      state_d = IDLE;
      min_d = '0;
      sec_d = '0;
    end else if (stop) begin
      state_d = run ? PAUSED : state_q;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSED) && !(dir && zero)) begin
        state_d = RUNNING;
        mode_d = dir;
      end
    end else if (load && !run) begin
      state_d = IDLE;
      min_d = load_min > MAXM ? MAXM : load_min;
      sec_d = load_sec > 6'd59 ? 6'd59 : load_sec;
    end
    if (run && !rst && !stop) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick && !mode_q) begin
        sec_d = sec_q == 6'd59 ? 6'd0 : sec_q + 1'b1;
        min_d = sec_q != 6'd59 ? min_q : min_q == MAXM ? '0 : min_q + 1'b1;
      end else if (tick) begin
        sec_d = sec_q == 6'd0 ? 6'd59 : sec_q - 1'b1;
        min_d = sec_q == 6'd0 ? min_q - 1'b1 : min_q;
        expired_d = min_q == '0 && sec_q == 6'd1;
        state_d = expired_d ? EXPIRED : state_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q <= '0;
      sec_q <= '0;
      pre_q <= '0;
      mode_q <= 1'b0;
      lap_min_q <= '0;
      lap_sec_q <= '0;
      lap_valid_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      sec_q <= sec_d;
      pre_q <= pre_d;
      mode_q <= mode_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      lap_valid_q <= lap_valid_d;
      expired_q <= expired_d;
    end
  end
  assign minutes = min_q;
  assign seconds = sec_q;
  assign lap_min = lap_min_q;
  assign lap_sec = lap_sec_q;
  assign lap_valid = lap_valid_q;
  assign status = state_q;
  assign expired = expired_q;
endmodule
